// File: rtl/control_memory.sv
`default_nettype none
// ============================================================================
// Module  : control_memory
// Brief   : Microcode store. It loads itself from a built-in default table after
//           reset, gives a registered read and accepts run-time microword patches.
//           Optional define: PARITY_CHECK_EN (even parity per word, sticky parity_err)
// Revision: 1.0 - initial release
// ============================================================================
module control_memory #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] micro_addr,
  output logic [DATA_W-1:0] control_signal,
  output logic              cm_ready,
  input  logic              patch_valid,
  input  logic [ADDR_W-1:0] patch_addr,
  input  logic [DATA_W-1:0] patch_data,
  output logic              patch_ready,
  output logic              parity_err
);

  localparam int DEPTH = 2**ADDR_W;
`ifdef PARITY_CHECK_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam logic [DATA_W-1:0] C_SAFE_WORD = DATA_W'(4);

  typedef enum logic [0:0] {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_init_ptr;
  logic [MEM_W-1:0]  r_mem [DEPTH];

  logic              w_patch_acc;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [MEM_W-1:0]  w_wword;
  logic [MEM_W-1:0]  w_rword;
  logic              w_rbad;

  // Fetch/decode entry (0x00-0x03) plus two short routines. Every other address returns to fetch.
  function automatic logic [DATA_W-1:0] default_word(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] w;
    case (32'(a))
      32'h00:  w = DATA_W'(32'h0001_0001);
      32'h01:  w = DATA_W'(32'h0002_0001);
      32'h02:  w = DATA_W'(32'h0004_0001);
      32'h03:  w = DATA_W'(32'h0008_0002);
      32'h10:  w = DATA_W'(32'h0010_0001);
      32'h11:  w = DATA_W'(32'h0020_0004);
      32'h20:  w = DATA_W'(32'h0040_0001);
      32'h21:  w = DATA_W'(32'h0080_0001);
      32'h22:  w = DATA_W'(32'h0100_0004);
      default: w = C_SAFE_WORD;
    endcase
    return w;
  endfunction

  assign patch_ready = (r_state == S_RUN);
  assign w_patch_acc = patch_valid && patch_ready;

  // The single write port is shared. Init owns it until RUN, and patches own it after that.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_init_ptr;
    w_wdata = default_word(r_init_ptr);
    if (r_state == S_INIT) begin
      w_we = 1'b1;
    end else if (w_patch_acc) begin
      w_we    = 1'b1;
      w_waddr = patch_addr;
      w_wdata = patch_data;
    end
  end

`ifdef PARITY_CHECK_EN
  assign w_wword = {^w_wdata, w_wdata};
  assign w_rword = r_mem[micro_addr];
  assign w_rbad  = ^w_rword;
`else
  assign w_wword = w_wdata;
  assign w_rword = r_mem[micro_addr];
  assign w_rbad  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wword;
    end
  end

  // The read samples the old contents, so a patch to the same address becomes visible on the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_INIT;
      r_init_ptr     <= '0;
      control_signal <= '0;
      cm_ready       <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_init_ptr <= r_init_ptr + ADDR_W'(1);
          if (r_init_ptr == ADDR_W'(DEPTH - 1)) begin
            r_state  <= S_RUN;
            cm_ready <= 1'b1;
          end
        end
        default: begin
          control_signal <= w_rbad ? C_SAFE_WORD : w_rword[DATA_W-1:0];
        end
      endcase
    end
  end

`ifdef PARITY_CHECK_EN
  logic r_parity_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity_err <= 1'b0;
    end else if (r_state == S_RUN && w_rbad) begin
      r_parity_err <= 1'b1;
    end
  end
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire
